// File: rtl/obf_ctrl_pkg.sv
// Shared types and width helpers for the key loader.
// The state encoding and counter sizing live here so the top and the shadow register agree.
package obf_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_READY  = 3'd3,
        ST_ERROR  = 3'd4
    } state_e;

    localparam int KEY_W_DEF      = 2;
    localparam int TIMEOUT_DEF    = 15;
    localparam int SETTLE_CYC_DEF = 2;

    // Width of a counter that must be able to hold max_val itself.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/obf_key_shadow.sv
// Key shadow register plus the committed key register driven to the locked core.
// Partial keys stay in the shadow; the committed key changes only on commit or zero.
module obf_key_shadow
    import obf_ctrl_pkg::*;
#(
    parameter int KEY_W = KEY_W_DEF,
    parameter int IDX_W = cnt_width(KEY_W_DEF)
) (
    input  logic             CK,
    input  logic             RSTN,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_bit,
    input  logic             commit,
    input  logic             zero,
    output logic [KEY_W-1:0] key
);

    logic [KEY_W-1:0] shadow_d, shadow_q;
    logic [KEY_W-1:0] key_d, key_q;

    always_comb begin
        shadow_d = shadow_q;
        if (wr_en) begin
            for (int i = 0; i < KEY_W; i++) begin
                if (wr_idx == IDX_W'(i)) shadow_d[i] = wr_bit;
            end
        end
        // Commit takes the updated shadow so the final bit lands in the same cycle.
        key_d = key_q;
        if (zero)        key_d = '0;
        else if (commit) key_d = shadow_d;
    end

    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            shadow_q <= '0;
            key_q    <= '0;
        end else begin
            shadow_q <= shadow_d;
            key_q    <= key_d;
        end
    end

    assign key = key_q;

endmodule

// File: rtl/obf_key_loader.sv
// Serial key loader for a logic-locked core: pulls bits over valid/ready, commits atomically,
// and holds the core clock-enable low until the committed key has settled.
//
//   state  | meaning
//   IDLE   | post-reset, no key loaded, core disabled
//   LOAD   | accepting key bits, idle-cycle watchdog running
//   SETTLE | key committed, waiting for key paths to settle
//   READY  | core enabled with committed key
//   ERROR  | key store stalled, key zeroed, core disabled
module obf_key_loader
    import obf_ctrl_pkg::*;
#(
    parameter int KEY_W      = KEY_W_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
    input  logic             CK,
    input  logic             RSTN,
    input  logic             start,
    input  logic             kv_valid,
    input  logic             kv_bit,
    output logic             kv_ready,
    output logic [KEY_W-1:0] keyinput,
    output logic             core_en,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int BIT_W = cnt_width(KEY_W);
    localparam int TO_W  = cnt_width(TIMEOUT);
    localparam int ST_W  = cnt_width(SETTLE_CYC);

    state_e           state_d, state_q;
    logic [BIT_W-1:0] bit_cnt_d, bit_cnt_q;
    logic [TO_W-1:0]  to_cnt_d, to_cnt_q;
    logic [ST_W-1:0]  settle_cnt_d, settle_cnt_q;
    logic             kv_ready_d, kv_ready_q;
    logic             core_en_d, core_en_q;
    logic             busy_d, busy_q;
    logic             done_d, done_q;
    logic             err_d, err_q;

    logic xfer;
    logic last_bit;
    logic sh_wr, sh_commit, sh_zero;

    assign xfer     = kv_valid & kv_ready_q;
    assign last_bit = (bit_cnt_q == BIT_W'(KEY_W - 1));

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        to_cnt_d     = to_cnt_q;
        settle_cnt_d = settle_cnt_q;
        kv_ready_d   = 1'b0;
        core_en_d    = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        err_d        = 1'b0;
        sh_wr        = 1'b0;
        sh_commit    = 1'b0;
        sh_zero      = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_READY, ST_ERROR: begin
                core_en_d = (state_q == ST_READY);
                err_d     = (state_q == ST_ERROR);
                if (start) begin
                    state_d    = ST_LOAD;
                    bit_cnt_d  = '0;
                    to_cnt_d   = '0;
                    kv_ready_d = 1'b1;
                    busy_d     = 1'b1;
                    core_en_d  = 1'b0;
                    err_d      = 1'b0;
                end
            end
            ST_LOAD: begin
                kv_ready_d = 1'b1;
                busy_d     = 1'b1;
                if (xfer) begin
                    sh_wr     = 1'b1;
                    to_cnt_d  = '0;
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    if (last_bit) begin
                        sh_commit    = 1'b1;
                        kv_ready_d   = 1'b0;
                        settle_cnt_d = ST_W'(SETTLE_CYC - 1);
                        state_d      = ST_SETTLE;
                    end
                end else if (to_cnt_q == TO_W'(TIMEOUT)) begin
                    sh_zero    = 1'b1;
                    kv_ready_d = 1'b0;
                    busy_d     = 1'b0;
                    err_d      = 1'b1;
                    state_d    = ST_ERROR;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            ST_SETTLE: begin
                busy_d = 1'b1;
                if (settle_cnt_q == '0) begin
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    core_en_d = 1'b1;
                    state_d   = ST_READY;
                end else begin
                    settle_cnt_d = settle_cnt_q - ST_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            to_cnt_q     <= '0;
            settle_cnt_q <= '0;
            kv_ready_q   <= 1'b0;
            core_en_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            to_cnt_q     <= to_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            kv_ready_q   <= kv_ready_d;
            core_en_q    <= core_en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    obf_key_shadow #(
        .KEY_W (KEY_W),
        .IDX_W (BIT_W)
    ) u_shadow (
        .CK     (CK),
        .RSTN   (RSTN),
        .wr_en  (sh_wr),
        .wr_idx (bit_cnt_q),
        .wr_bit (kv_bit),
        .commit (sh_commit),
        .zero   (sh_zero),
        .key    (keyinput)
    );

    assign kv_ready = kv_ready_q;
    assign core_en  = core_en_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule
